bus_arbiter_rr: RTL
===================

// Module: bus_arbiter_rr
// PURPOSE
//  Round-robin arbiter sharing the system bus between NUM_MASTERS masters.
//  Masters include local masters and the bus-bridge master, which issues bus addresses from
//  the bridge address converter. The arbiter grants one master at a time and holds the grant
//  until the transaction completes, the master drops its request, or a timeout expires.
//  It then inserts one idle turnaround cycle and drives the select index for the bus mux.
// PARAMETERS
//  NUM_MASTERS    2    number of requesting masters (>=2)
//  SEL_WIDTH      1    width of m_sel; must equal $clog2(NUM_MASTERS)
//  TIMEOUT_CYCLES 1024 max cycles a grant may be held before forced release (>=2)
//  CNT_WIDTH      11   hold-counter width; must hold TIMEOUT_CYCLES-1
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rst        in   1            synchronous reset, active-high
//  m_req      in   NUM_MASTERS  per-master bus request, level, held until done
//  trans_done in   1            1-cycle pulse from bus/slave side: current transaction ended
//  m_grant    out  NUM_MASTERS  one-hot grant, registered
//  m_sel      out  SEL_WIDTH    index of granted master, valid while bus_busy
//  bus_busy   out  1            high while any grant is asserted
//  timeout    out  1            1-cycle pulse when a grant is force-released
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - m_grant=0, m_sel=0, bus_busy=0, timeout=0, state=IDLE, hold counter=0.
//   - last_ptr=NUM_MASTERS-1, so master 0 has first priority.
//   - Reset mid-grant drops the grant on the next edge with no timeout pulse.
//  States:
//   - IDLE:
//     - If m_req!=0, pick the first requester searching upward from last_ptr+1 (mod NUM_MASTERS).
//     - Next edge: set that m_grant bit, m_sel=index, last_ptr=index, counter=0, go to GRANT.
//     - Latency: req to grant is 1 cycle.
//   - GRANT:
//     - Grant is held and the counter increments each cycle, saturating.
//     - Release conditions, evaluated in this priority order:
//       (a) trans_done=1;
//       (b) m_req[m_sel]=0;
//       (c) counter==TIMEOUT_CYCLES-1, which also pulses timeout for 1 cycle.
//     - On any release: next edge clears m_grant and goes to TURN.
//     - Requests from other masters never preempt the current grant.
//   - TURN:
//     - Exactly one cycle with m_grant=0 and bus_busy=0 (bus turnaround).
//     - Then IDLE, which can grant again on the following edge.
//     - Minimum release-to-next-grant gap is 2 cycles.
//  Output rules:
//   - bus_busy = |m_grant, registered with the grant.
//   - m_sel holds its last value outside GRANT.
//   - m_grant is always one-hot or zero.
//  Boundary and simultaneous events:
//   - trans_done together with timeout condition: release as trans_done, with no timeout pulse.
//   - trans_done in IDLE or TURN: ignored.
//   - Request re-raised by the just-released master: it competes in round-robin order,
//     so other pending masters win first.
//   - Single requester: it is re-granted after each TURN.
//   - Pointer wraps from NUM_MASTERS-1 to 0.
// TESTING
//  1. Reset:
//     - Stimulus: rst high 2 cycles, m_req=2'b11.
//     - Required: grant=0 during reset; grant=2'b01, m_sel=0 one cycle after rst falls.
//  2. Round-robin:
//     - Stimulus: m_req=2'b11 held; trans_done pulses 3 cycles after each grant.
//     - Required: grants alternate 01,10,01; each is separated by one TURN cycle with grant=0.
//  3. Request drop:
//     - Stimulus: master 1 granted, then m_req[1] falls.
//     - Required: grant=0 on the next edge; timeout stays 0.
//  4. Timeout:
//     - Stimulus: TIMEOUT_CYCLES=8, m_req=2'b01, no trans_done.
//     - Required: timeout pulses at hold cycle 7; grant clears next edge; re-granted after TURN.
//  5. Simultaneous:
//     - Stimulus: trans_done coincides with counter==TIMEOUT_CYCLES-1.
//     - Required: release occurs and timeout=0.
//  6. Mid-grant reset:
//     - Stimulus: rst pulsed during GRANT of master 1.
//     - Required: grant=0 next edge; master 0 is granted first after reset.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter.
// Grants one master at a time, holds the grant until the transaction ends,
// the master withdraws its request, or the hold limit is reached. Each release
// is followed by a single idle turnaround cycle before the next grant.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS    = 2,
  parameter int SEL_WIDTH      = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic                   trans_done,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [SEL_WIDTH-1:0]   m_sel,
  output logic                   bus_busy,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int                     SW1       = SEL_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0]   LAST_IDX  = SEL_WIDTH'(NUM_MASTERS - 1);
  localparam logic [SW1-1:0]         NUM_M_W   = SW1'(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] GRANT_ONE = NUM_MASTERS'(1);

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [SEL_WIDTH-1:0]   last_ptr_q, last_ptr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   timeout_d;

  // Candidate master for each round-robin offset (offset 1 = just after last_ptr).
  logic [SEL_WIDTH-1:0]   cand_idx [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] cand_req;
  logic                   pick_valid;
  logic [SEL_WIDTH-1:0]   pick_idx;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
    logic [SW1-1:0] sum;
    assign sum          = {1'b0, last_ptr_q} + SW1'(gi + 1);
    assign cand_idx[gi] = (sum >= NUM_M_W) ? SEL_WIDTH'(sum - NUM_M_W) : SEL_WIDTH'(sum);
    assign cand_req[gi] = m_req[cand_idx[gi]];
  end

  // Pick the requesting candidate with the smallest offset from last_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

  // Next-state and timeout pulse; release causes are checked done, drop, then limit.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_ptr_d = last_ptr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d    = GRANT_ONE << pick_idx;
          sel_d      = pick_idx;
          last_ptr_d = pick_idx;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (trans_done || !m_req[sel_q] || (cnt_q == CNT_LIMIT)) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_TURN;
          // Forced release is only flagged when nothing else ended the grant.
          timeout_d = !trans_done && m_req[sel_q];
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset hands first priority to master 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      last_ptr_q <= LAST_IDX;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      last_ptr_q <= last_ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign m_grant  = grant_q;
  assign m_sel    = sel_q;
  assign bus_busy = busy_q;
  assign timeout  = timeout_d;

endmodule
